// File: rtl/myproject_mul_share_arb_if.sv
// Bundle of requester, shared-multiplier and response signals for the multiplier-sharing arbiter.
// slave is the arbiter's view; master is the surrounding environment's view.
interface myproject_mul_share_arb_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned A_W  = 16,
    parameter int unsigned B_W  = 6,
    parameter int unsigned P_W  = 22,
    parameter int unsigned ID_W = 2
);
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*A_W-1:0] req_a;
    logic [NREQ*B_W-1:0] req_b;
    logic [NREQ-1:0]     req_ready;
    logic [A_W-1:0]      mul_din0;
    logic [B_W-1:0]      mul_din1;
    logic [P_W-1:0]      mul_dout;
    logic                rsp_valid;
    logic [P_W-1:0]      rsp_data;
    logic [ID_W-1:0]     rsp_id;
    logic                rsp_ready;

    modport slave (
        input  req_valid, req_a, req_b, mul_dout, rsp_ready,
        output req_ready, mul_din0, mul_din1, rsp_valid, rsp_data, rsp_id
    );

    modport master (
        output req_valid, req_a, req_b, mul_dout, rsp_ready,
        input  req_ready, mul_din0, mul_din1, rsp_valid, rsp_data, rsp_id
    );
endinterface

// File: rtl/myproject_mul_share_arb.sv
// Round-robin arbiter sharing one combinational signed multiplier among NREQ requesters,
// with a 1-deep registered product/ID output slot.
module myproject_mul_share_arb #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned A_W  = 16,
    parameter int unsigned B_W  = 6,
    parameter int unsigned P_W  = 22,
    parameter int unsigned ID_W = 2
) (
    input logic                      ap_clk,
    input logic                      ap_rst,
    myproject_mul_share_arb_if.slave bus
);
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0] grant;
    logic [ID_W-1:0] next_ptr;
    logic            any_valid;
    logic            load;
    logic            accept;
    logic [A_W-1:0]  a_sel;
    logic [B_W-1:0]  b_sel;

    logic            rsp_valid_q, rsp_valid_d;
    logic [P_W-1:0]  rsp_data_q, rsp_data_d;
    logic [ID_W-1:0] rsp_id_q, rsp_id_d;

    // First valid requester at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin : grant_scan
        int unsigned idx;
        grant     = '0;
        any_valid = 1'b0;
        idx       = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = 32'(rr_ptr_q) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!any_valid && bus.req_valid[ID_W'(idx)]) begin
                any_valid = 1'b1;
                grant     = ID_W'(idx);
            end
        end
    end

    always_comb begin : operand_mux
        a_sel = '0;
        b_sel = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (ID_W'(i) == grant) begin
                a_sel = bus.req_a[i*A_W +: A_W];
                b_sel = bus.req_b[i*B_W +: B_W];
            end
        end
    end

    assign load     = !rsp_valid_q || bus.rsp_ready;
    assign accept   = load && any_valid && !ap_rst;
    assign next_ptr = (32'(grant) == NREQ - 1) ? '0 : grant + 1'b1;

    always_comb begin : ready_decode
        bus.req_ready = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            bus.req_ready[i] = accept && (ID_W'(i) == grant);
        end
    end

    // Drive zeros rather than stale operands when idle so nothing undefined reaches the multiplier.
    assign bus.mul_din0 = (any_valid && !ap_rst) ? a_sel : '0;
    assign bus.mul_din1 = (any_valid && !ap_rst) ? b_sel : '0;

    always_comb begin : next_state
        rr_ptr_d    = rr_ptr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        if (load) begin
            if (any_valid) begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = bus.mul_dout;
                rsp_id_d    = grant;
                rr_ptr_d    = next_ptr;
            end else begin
                rsp_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            rr_ptr_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_id    = rsp_id_q;
endmodule
